hog_block_gen: RTL and testbench

- Next-generation HOG block assembler.
- Accepts cell histograms in raster order and keeps one row of cells in an internal line buffer.
- Emits every overlapping 2x2 block (four cell histograms plus the block coordinate) to the downstream normaliser.
- Unlike the previous generation: parametrised bin count and width, runtime row length latched at start-of-frame, ready/valid backpressure on both sides, block-coordinate outputs, optional block-sum output.

---
 rtl/hog_block_gen.sv | 173 +++++++++++++++++
 tb/tb_hog_block_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_block_gen.sv
// hog_block_gen: HOG 2x2 block assembler.
//
// Accepts cell histograms in raster order, keeps one row of cells in a line
// buffer and emits every overlapping 2x2 block of cells together with the
// block's top-left coordinate. A single output register gives full
// throughput with ready/valid backpressure on both sides.
//
// Optional feature: define HOG_BLK_SUM_EN to build the block-sum adder that
// drives o_sum; without it o_sum is constant zero.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   cells_per_row      row length, latched on an accepted cell with i_sof
//   i_sof              first cell of a frame
//   i_valid/i_ready    input handshake
//   i_bin              cell histogram, bin k at [k*BIN_W +: BIN_W]
//   o_valid/o_ready    output handshake
//   o_blk_a..o_blk_d   top-left, top-right, bottom-left, bottom-right cells
//   o_row, o_col       block top-left coordinate
//   o_sum              sum of all 4*N_BINS bins of the block
module hog_block_gen #(
    parameter int unsigned N_BINS    = 9,
    parameter int unsigned BIN_W     = 32,
    parameter int unsigned MAX_CELLS = 40,
    parameter int unsigned COL_W     = 6,
    parameter int unsigned ROW_W     = 8,
    parameter int unsigned SUM_W     = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COL_W-1:0]        cells_per_row,
    input  logic                    i_sof,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [N_BINS*BIN_W-1:0] i_bin,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [N_BINS*BIN_W-1:0] o_blk_a,
    output logic [N_BINS*BIN_W-1:0] o_blk_b,
    output logic [N_BINS*BIN_W-1:0] o_blk_c,
    output logic [N_BINS*BIN_W-1:0] o_blk_d,
    output logic [ROW_W-1:0]        o_row,
    output logic [COL_W-1:0]        o_col,
    output logic [SUM_W-1:0]        o_sum
);

    localparam int unsigned VEC_W = N_BINS * BIN_W;
    localparam logic [COL_W-1:0] MAX_LEN = COL_W'(MAX_CELLS);

    logic [VEC_W-1:0] linebuf [MAX_CELLS];

    logic [ROW_W-1:0] row_q, row_d, r_eff;
    logic [COL_W-1:0] col_q, col_d, c_eff;
    logic [COL_W-1:0] len_q, len_eff;
    logic [VEC_W-1:0] top_d, prev_top_q, left_q;
    logic             accept, blk_load;

    logic             o_valid_q;
    logic [VEC_W-1:0] blk_a_q, blk_b_q, blk_c_q, blk_d_q;
    logic [ROW_W-1:0] o_row_q;
    logic [COL_W-1:0] o_col_q;

    assign i_ready = !o_valid_q || o_ready;

    // Position and row length that apply to the cell being offered; an
    // accepted sof cell restarts the frame at (0,0) with its own length.
    always_comb begin
        accept = i_valid && i_ready;
        if (i_sof) begin
            r_eff = '0;
            c_eff = '0;
            if (cells_per_row == '0 || cells_per_row > MAX_LEN)
                len_eff = MAX_LEN;
            else
                len_eff = cells_per_row;
        end else begin
            r_eff   = row_q;
            c_eff   = col_q;
            len_eff = len_q;
        end

        top_d    = linebuf[c_eff];
        blk_load = accept && (r_eff != '0) && (c_eff != '0);

        if (c_eff == len_eff - COL_W'(1)) begin
            col_d = '0;
            row_d = (&r_eff) ? r_eff : r_eff + ROW_W'(1);
        end else begin
            col_d = c_eff + COL_W'(1);
            row_d = r_eff;
        end
    end

    // Line buffer is deliberately not reset: row 0 of every frame rewrites
    // each entry before any block can read it.
    always_ff @(posedge clk) begin
        if (accept)
            linebuf[c_eff] <= i_bin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q      <= '0;
            col_q      <= '0;
            len_q      <= MAX_LEN;
            prev_top_q <= '0;
            left_q     <= '0;
            o_valid_q  <= 1'b0;
            blk_a_q    <= '0;
            blk_b_q    <= '0;
            blk_c_q    <= '0;
            blk_d_q    <= '0;
            o_row_q    <= '0;
            o_col_q    <= '0;
        end else begin
            if (accept) begin
                row_q      <= row_d;
                col_q      <= col_d;
                len_q      <= len_eff;
                prev_top_q <= top_d;
                left_q     <= i_bin;
            end
            // Accept implies the output is empty or transferring, so a new
            // block may overwrite it; otherwise a transfer empties it.
            if (blk_load) begin
                o_valid_q <= 1'b1;
                blk_a_q   <= prev_top_q;
                blk_b_q   <= top_d;
                blk_c_q   <= left_q;
                blk_d_q   <= i_bin;
                o_row_q   <= r_eff - ROW_W'(1);
                o_col_q   <= c_eff - COL_W'(1);
            end else if (o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

`ifdef HOG_BLK_SUM_EN
    logic [SUM_W-1:0] sum_d, sum_q;

    always_comb begin
        sum_d = '0;
        for (int unsigned k = 0; k < N_BINS; k++) begin
            sum_d = sum_d
                  + SUM_W'(prev_top_q[k*BIN_W +: BIN_W])
                  + SUM_W'(top_d[k*BIN_W +: BIN_W])
                  + SUM_W'(left_q[k*BIN_W +: BIN_W])
                  + SUM_W'(i_bin[k*BIN_W +: BIN_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_q <= '0;
        else if (blk_load)
            sum_q <= sum_d;
    end

    assign o_sum = sum_q;
`else
    assign o_sum = '0;
`endif

    assign o_valid = o_valid_q;
    assign o_blk_a = blk_a_q;
    assign o_blk_b = blk_b_q;
    assign o_blk_c = blk_c_q;
    assign o_blk_d = blk_d_q;
    assign o_row   = o_row_q;
    assign o_col   = o_col_q;

endmodule

// File: tb/tb_hog_block_gen.sv
module tb_hog_block_gen;

    localparam int N_BINS = 9;
    localparam int BIN_W  = 32;
    localparam int VEC_W  = N_BINS * BIN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       cells_per_row = '0;
    logic             i_sof = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [VEC_W-1:0] i_bin = '0;
    logic             o_valid;
    logic             o_ready = 1'b1;
    logic [VEC_W-1:0] o_blk_a, o_blk_b, o_blk_c, o_blk_d;
    logic [7:0]       o_row;
    logic [5:0]       o_col;
    logic [37:0]      o_sum;

    hog_block_gen #(
        .N_BINS(9), .BIN_W(32), .MAX_CELLS(40), .COL_W(6), .ROW_W(8), .SUM_W(38)
    ) dut (
        .clk(clk), .rst(rst), .cells_per_row(cells_per_row), .i_sof(i_sof),
        .i_valid(i_valid), .i_ready(i_ready), .i_bin(i_bin),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_blk_a(o_blk_a), .o_blk_b(o_blk_b), .o_blk_c(o_blk_c), .o_blk_d(o_blk_d),
        .o_row(o_row), .o_col(o_col), .o_sum(o_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, c, d;
        logic [7:0]  row;
        logic        row_chk;
        logic [5:0]  col;
        logic [37:0] sum;
    } blk_t;

    blk_t sb[$];
    blk_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   blk_cnt  = 0;

    function automatic logic [31:0] cval(input logic [31:0] base, input logic [31:0] stride,
                                         input logic [31:0] cstride, input int r, input int c);
        logic [31:0] r32, c32;
        r32 = r;
        c32 = c;
        return base + stride * r32 + cstride * c32;
    endfunction

    function automatic logic [VEC_W-1:0] rep(input logic [31:0] v);
        return {N_BINS{v}};
    endfunction

    // Scoreboard monitor: a block is popped on every cycle it will transfer.
    always @(negedge clk) begin
        if (!rst && o_valid === 1'b1 && o_ready === 1'b1) begin
            blk_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_block got row=%0d col=%0d a0=%h, required no block",
                         o_row, o_col, o_blk_a[31:0]);
            end else begin
                mon_e = sb.pop_front();
                n_checks++;
                if (o_blk_a !== rep(mon_e.a) || o_blk_b !== rep(mon_e.b) ||
                    o_blk_c !== rep(mon_e.c) || o_blk_d !== rep(mon_e.d))
                    $display("FAIL blk_data got a=%h b=%h c=%h d=%h, required a=%h b=%h c=%h d=%h",
                             o_blk_a[31:0], o_blk_b[31:0], o_blk_c[31:0], o_blk_d[31:0],
                             mon_e.a, mon_e.b, mon_e.c, mon_e.d);
                else
                    n_pass++;
                n_checks++;
                if ((mon_e.row_chk && o_row !== mon_e.row) || o_col !== mon_e.col)
                    $display("FAIL blk_coord got row=%0d col=%0d, required row=%0d col=%0d",
                             o_row, o_col, mon_e.row, mon_e.col);
                else
                    n_pass++;
                n_checks++;
                if (o_sum !== mon_e.sum)
                    $display("FAIL blk_sum got %h, required %h", o_sum, mon_e.sum);
                else
                    n_pass++;
            end
        end
    end

    // Drives n cells from posedge+1; pushes the expected block for every
    // cell at r>=1,c>=1 and optionally checks the one-cycle latency.
    task automatic send(input int n, input int len, input logic [5:0] cpr, input logic sof,
                        input logic [31:0] base, input logic [31:0] stride,
                        input logic [31:0] cstride, input bit lat);
        int          r, c, waitc;
        blk_t        e;
        bit          pend;
        logic [7:0]  prow;
        logic [5:0]  pcol;
        logic [37:0] s;
        pend = 1'b0;
        prow = '0;
        pcol = '0;
        for (int i = 0; i < n; i++) begin
            r = i / len;
            c = i % len;
            i_valid       = 1'b1;
            i_bin         = rep(cval(base, stride, cstride, r, c));
            i_sof         = sof && (i == 0);
            cells_per_row = cpr;
            waitc         = 0;
            forever begin
                @(negedge clk);
                if (pend) begin
                    n_checks++;
                    if (o_valid !== 1'b1 || o_row !== prow || o_col !== pcol)
                        $display("FAIL latency got valid=%b row=%0d col=%0d, required valid=1 row=%0d col=%0d",
                                 o_valid, o_row, o_col, prow, pcol);
                    else
                        n_pass++;
                    pend = 1'b0;
                end
                if (i_ready === 1'b1) break;
                waitc++;
                if (waitc > 100) begin
                    n_checks++;
                    $display("FAIL accept_timeout got i_ready=%b for cell %0d, required 1 within 100 cycles",
                             i_ready, i);
                    i_valid = 1'b0;
                    i_sof   = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
            if (r >= 1 && c >= 1) begin
                e.a = cval(base, stride, cstride, r - 1, c - 1);
                e.b = cval(base, stride, cstride, r - 1, c);
                e.c = cval(base, stride, cstride, r, c - 1);
                e.d = cval(base, stride, cstride, r, c);
                e.row_chk = (r - 1 <= 254);
                e.row = (r - 1 > 255) ? 8'd255 : 8'(r - 1);
                e.col = 6'(c - 1);
`ifdef HOG_BLK_SUM_EN
                s = {6'd0, e.a} + {6'd0, e.b} + {6'd0, e.c} + {6'd0, e.d};
                e.sum = s * 38'd9;
`else
                s = '0;
                e.sum = s;
`endif
                sb.push_back(e);
                if (lat) begin
                    pend = 1'b1;
                    prow = e.row;
                    pcol = e.col;
                end
            end
            @(posedge clk);
            #1;
        end
        i_sof = 1'b0;
        if (pend) begin
            i_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (o_valid !== 1'b1 || o_row !== prow || o_col !== pcol)
                $display("FAIL latency got valid=%b row=%0d col=%0d, required valid=1 row=%0d col=%0d",
                         o_valid, o_row, o_col, prow, pcol);
            else
                n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1)
            $display("FAIL reset_valid got o_valid=%b i_ready=%b, required 0 1", o_valid, i_ready);
        else
            n_pass++;
        n_checks++;
        if (o_row !== 8'd0 || o_col !== 6'd0)
            $display("FAIL reset_coord got row=%0d col=%0d, required 0 0", o_row, o_col);
        else
            n_pass++;
        n_checks++;
        if (o_blk_a !== '0 || o_blk_b !== '0 || o_blk_c !== '0 || o_blk_d !== '0 || o_sum !== '0)
            $display("FAIL reset_data got a0=%h d0=%h sum=%h, required 0", o_blk_a[31:0], o_blk_d[31:0], o_sum);
        else
            n_pass++;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input int want);
        n_checks++;
        if (blk_cnt !== want || sb.size() != 0)
            $display("FAIL block_count got %0d (pending %0d), required %0d (pending 0)",
                     blk_cnt, sb.size(), want);
        else
            n_pass++;
    endtask

    task automatic test_rows;
        blk_cnt = 0;
        send(12, 4, 6'd4, 1'b1, 32'h0, 32'd16, 32'd1, 1'b1);
        idle(4);
        check_count(6);
    endtask

    task automatic test_backpressure;
        logic [VEC_W-1:0] sa, sb_, sc, sd;
        logic [7:0]       srow;
        logic [5:0]       scol;
        bit               found;
        blk_cnt = 0;
        fork
            send(12, 4, 6'd4, 1'b1, 32'h100, 32'd16, 32'd1, 1'b0);
            begin
                found = 1'b0;
                for (int w = 0; w < 50; w++) begin
                    @(posedge clk);
                    #2;
                    if (o_valid === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (!found) begin
                    n_checks++;
                    $display("FAIL stall_wait got o_valid=%b, required 1 within 50 cycles", o_valid);
                end else begin
                    o_ready = 1'b0;
                    sa = o_blk_a; sb_ = o_blk_b; sc = o_blk_c; sd = o_blk_d;
                    srow = o_row; scol = o_col;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        n_checks++;
                        if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_blk_a !== sa || o_blk_b !== sb_ ||
                            o_blk_c !== sc || o_blk_d !== sd || o_row !== srow || o_col !== scol)
                            $display("FAIL stall_hold got i_ready=%b valid=%b row=%0d col=%0d, required 0 1 %0d %0d",
                                     i_ready, o_valid, o_row, o_col, srow, scol);
                        else
                            n_pass++;
                    end
                    @(posedge clk);
                    #2 o_ready = 1'b1;
                end
            end
        join
        idle(4);
        check_count(6);
    endtask

    task automatic test_midframe_sof;
        blk_cnt = 0;
        send(7, 4, 6'd4, 1'b1, 32'h0, 32'd16, 32'd1, 1'b0);
        send(6, 3, 6'd3, 1'b1, 32'h1000, 32'd16, 32'd1, 1'b1);
        idle(4);
        check_count(4);
    endtask

    task automatic test_len_edges;
        blk_cnt = 0;
        send(4, 1, 6'd1, 1'b1, 32'h200, 32'd16, 32'd1, 1'b0);
        idle(3);
        check_count(0);
        blk_cnt = 0;
        send(80, 40, 6'd0, 1'b1, 32'h300, 32'd256, 32'd1, 1'b0);
        idle(3);
        check_count(39);
        blk_cnt = 0;
        send(80, 40, 6'd50, 1'b1, 32'h7000, 32'd256, 32'd1, 1'b0);
        idle(3);
        check_count(39);
    endtask

    task automatic test_sum;
        blk_cnt = 0;
        send(4, 2, 6'd2, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
        idle(3);
        check_count(1);
    endtask

    task automatic test_row_sat;
        blk_cnt = 0;
        send(516, 2, 6'd2, 1'b1, 32'h0, 32'd4, 32'd1, 1'b0);
        idle(3);
        check_count(257);
    endtask

    task automatic test_reset_midstream;
        send(6, 4, 6'd4, 1'b1, 32'h500, 32'd16, 32'd1, 1'b0);
        i_valid = 1'b0;
        n_checks++;
        if (o_valid !== 1'b1)
            $display("FAIL pre_reset_valid got %b, required 1", o_valid);
        else
            n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_row !== 8'd0 || o_col !== 6'd0)
            $display("FAIL async_reset got valid=%b row=%0d col=%0d, required 0 0 0", o_valid, o_row, o_col);
        else
            n_pass++;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        blk_cnt = 0;
        // No sof: counters and the default row length must come from reset.
        send(42, 40, 6'd4, 1'b0, 32'h600, 32'd256, 32'd1, 1'b1);
        idle(3);
        check_count(1);
    endtask

    initial begin
        test_reset();
        test_rows();
        test_backpressure();
        test_midframe_sof();
        test_len_edges();
        test_sum();
        test_row_sat();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
